// File: rtl/shift_ctrl_pipe.sv
// shift_ctrl_pipe: two-stage shift/rotate front end (select-code stage, mux stage).
// Define SHIFT_CTRL_FLAGS_EN to generate and pipeline the ZERO/CARRY flags.
module shift_ctrl_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] operand,
    input  logic [3:0] shamt,
    input  logic [1:0] shift_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       zero,
    output logic       carry
);
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} shift_op_e;

    logic            s1_valid;
    shift_op_e       s1_op;
    logic [7:0]      s1_data;
    logic [7:0][3:0] s1_sel;
    logic [7:0][3:0] sel_next;
    logic [7:0]      op_rev;
    logic [7:0]      bit_val;
    logic [7:0]      bit_rev;
    logic [7:0]      res_next;
    logic            s1_adv;
    logic            s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        logic [4:0] sum;
        assign sum         = {1'b0, shamt} + 5'(i);
        assign op_rev[i]   = operand[7-i];
        assign sel_next[i] = (shift_op == OP_ROR) ? {shamt[3], shamt[2:0] + 3'(i)}
                           : (sum[4] ? 4'hf : sum[3:0]);
        // Rotation ignores code bit 3: the low bits already wrap mod 8.
        assign bit_val[i]  = (s1_sel[i][3] && s1_op != OP_ROR)
                           ? (s1_op == OP_SRA && s1_data[7]) : s1_data[s1_sel[i][2:0]];
        assign bit_rev[i]  = bit_val[7-i];
    end

    assign res_next = (s1_op == OP_SLL) ? bit_rev : bit_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_SLL;
            s1_data  <= '0;
            s1_sel   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= shift_op_e'(shift_op);
                s1_data <= (shift_op == OP_SLL) ? op_rev : operand;
                s1_sel  <= sel_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) result <= res_next;
        end
    end

`ifdef SHIFT_CTRL_FLAGS_EN
    logic [2:0] idx_dec;
    logic [2:0] idx_neg;
    logic       in_range;
    logic       carry_next;
    logic       s1_carry;

    // Shift-out position: s-1 for right shifts and rotate, 8-s for left shift.
    assign idx_dec    = shamt[2:0] - 3'd1;
    assign idx_neg    = 3'd0 - shamt[2:0];
    assign in_range   = shamt <= 4'd8;
    assign carry_next = (shamt == 4'd0) ? 1'b0
                      : (shift_op == OP_SRL) ? (in_range && operand[idx_dec])
                      : (shift_op == OP_SLL) ? (in_range && operand[idx_neg])
                      : (shift_op == OP_SRA) ? (shamt[3] ? operand[7] : operand[idx_dec])
                      : operand[idx_dec];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_carry <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
        end else begin
            if (s1_adv && in_valid) s1_carry <= carry_next;
            if (s2_adv && s1_valid) begin
                zero  <= (res_next == 8'h00);
                carry <= s1_carry;
            end
        end
    end
`else
    assign zero  = 1'b0;
    assign carry = 1'b0;
`endif
endmodule
